data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_pkg.sv | 18 +
 rtl/dmem_array.sv | 27 ++
 rtl/data_mem_responder.sv | 123 ++++++++++++
 tb/tb_data_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants, FSM encoding and address-fault helper for the MEM-stage data responder.
package data_mem_pkg;

    localparam int unsigned DEPTH_DEFAULT   = 64;
    localparam int unsigned LATENCY_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // A byte address faults if it is not word aligned or reaches past the last word.
    function automatic logic addr_fault(input logic [31:0] addr, input int unsigned aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 32'd2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 data word store: synchronous write, combinational read, async active-low clear.
module dmem_array #(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder for the MEM stage: accepts one access at a time,
// holds the pipeline while it is in flight and returns a single-cycle response strobe.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEFAULT,
    parameter int unsigned LATENCY = LATENCY_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [2:0]  CNT_LOAD = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic          accept;
    logic          enter_resp;
    logic          acc_write;
    logic          acc_fault;
    logic          mem_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   resp_rdata_d;
    logic [AW-1:0] acc_idx;

    assign accept = (state_q == IDLE) && req_valid;

    // With LATENCY=1 the access enters RESP on its own accepting edge, so the live
    // request is used while IDLE and the captured copy afterwards.
    assign acc_write = (state_q == IDLE) ? req_write : wr_q;
    assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign acc_idx   = acc_addr[AW+1:2];
    assign acc_fault = addr_fault(acc_addr, AW);

    assign enter_resp   = (accept && (LATENCY == 32'd1)) ||
                          ((state_q == WAIT) && (cnt_q == 3'd0));
    assign mem_we       = enter_resp && acc_write && !acc_fault;
    assign resp_rdata_d = (acc_write || acc_fault) ? '0 : mem_rdata;

    dmem_array #(
        .DEPTH(DEPTH)
    ) u_dmem_array (
        .clk_i  (Clk),
        .rst_ni (Reset),
        .we_i   (mem_we),
        .addr_i (acc_idx),
        .wdata_i(acc_wdata),
        .rdata_o(mem_rdata)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            if (enter_resp) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= acc_fault;
                resp_rdata_q <= resp_rdata_d;
            end
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (LATENCY == 32'd1) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign stall      = accept || (state_q == WAIT);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: four instances (LATENCY 1..4) share one request stream
// and are compared every cycle against a transaction-level reference model.
module tb_data_mem_responder;

    localparam int NL    = 4;
    localparam int DEPTH = 64;

    logic        Clk       = 1'b0;
    logic        Reset     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;

    logic [NL-1:0] ready;
    logic [NL-1:0] rv;
    logic [NL-1:0] rerr;
    logic [NL-1:0] stl;
    logic [31:0]   rdata [NL];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        data_mem_responder #(
            .DEPTH  (DEPTH),
            .LATENCY(g + 1)
        ) u_dut (
            .Clk       (Clk),
            .Reset     (Reset),
            .req_valid (req_valid),
            .req_write (req_write),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .req_ready (ready[g]),
            .resp_valid(rv[g]),
            .resp_rdata(rdata[g]),
            .resp_err  (rerr[g]),
            .stall     (stl[g])
        );
    end

    initial forever #5 Clk = ~Clk;

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void chk(input string name, input int lane,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s lane=%0d (LATENCY=%0d) actual=%0h expected=%0h",
                     name, lane, lane + 1, act, exp);
        end
    endfunction

    function automatic bit ref_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
    endfunction

    // Reference model: one outstanding transaction per lane, answered exactly
    // LATENCY cycles after the cycle in which it was accepted.
    logic [31:0] mmem  [NL][DEPTH];
    bit          busy  [NL];
    int          rcyc  [NL];
    bit          twr   [NL];
    logic [31:0] taddr [NL];
    logic [31:0] tdata [NL];

    initial begin : monitor
        logic        e_rdy, e_stl, e_rv, e_err;
        logic [31:0] e_rd;
        bit          flt;
        forever begin
            @(negedge Clk);
            for (int g = 0; g < NL; g++) begin
                e_rdy = 1'b1;
                e_stl = req_valid;
                e_rv  = 1'b0;
                e_err = 1'b0;
                e_rd  = '0;
                if (!Reset) begin
                    busy[g] = 1'b0;
                    for (int i = 0; i < DEPTH; i++) mmem[g][i] = '0;
                end else if (busy[g]) begin
                    e_rdy = 1'b0;
                    if (cyc < rcyc[g]) begin
                        e_stl = 1'b1;
                    end else begin
                        e_stl = 1'b0;
                        e_rv  = 1'b1;
                        flt   = ref_fault(taddr[g]);
                        e_err = flt;
                        if (!flt && !twr[g]) e_rd = mmem[g][taddr[g][7:2]];
                        if (!flt && twr[g])  mmem[g][taddr[g][7:2]] = tdata[g];
                        busy[g] = 1'b0;
                    end
                end else if (req_valid) begin
                    busy[g]  = 1'b1;
                    rcyc[g]  = cyc + g + 1;
                    twr[g]   = req_write;
                    taddr[g] = req_addr;
                    tdata[g] = req_wdata;
                end
                chk("req_ready",  g, 32'(ready[g]), 32'(e_rdy));
                chk("stall",      g, 32'(stl[g]),   32'(e_stl));
                chk("resp_valid", g, 32'(rv[g]),    32'(e_rv));
                chk("resp_err",   g, 32'(rerr[g]),  32'(e_err));
                chk("resp_rdata", g, rdata[g],      e_rd);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, '0, '0);
        Reset = 1'b0;
        repeat (2) tick();
        Reset = 1'b1;
    endtask

    int          lat       [NL];
    int          stall_cnt [NL];
    int          pulses    [NL];
    logic [31:0] got_rd    [NL];
    logic        got_err   [NL];
    logic        resp_stl  [NL];

    // Single-cycle request issued while every lane is idle; checks per-lane timing.
    task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d);
        for (int g = 0; g < NL; g++) begin
            lat[g] = -1; stall_cnt[g] = 0; pulses[g] = 0;
            got_rd[g] = 'x; got_err[g] = 1'bx; resp_stl[g] = 1'bx;
        end
        drive(1'b1, w, a, d);
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            for (int g = 0; g < NL; g++) begin
                if (stl[g]) stall_cnt[g]++;
                if (rv[g]) begin
                    pulses[g]++;
                    if (lat[g] < 0) begin
                        lat[g] = k; got_rd[g] = rdata[g]; got_err[g] = rerr[g]; resp_stl[g] = stl[g];
                    end
                end
            end
            tick();
            if (k == 0) drive(1'b0, 1'b0, '0, '0);
        end
        for (int g = 0; g < NL; g++) begin
            chk("resp_latency",  g, lat[g],       g + 1);
            chk("stall_cycles",  g, stall_cnt[g], g + 1);
            chk("resp_pulses",   g, pulses[g],    1);
            chk("stall_in_resp", g, 32'(resp_stl[g]), 32'd0);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    initial begin : stim
        vec_t vecs [10];
        int   cnt  [NL];
        int   pc   [$];
        int   r;
        logic [31:0] a;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h0000_0012, 32'h1111_1111, 1'b1, 32'h0000_0000};
        vecs[3] = '{1'b1, 32'h0000_0100, 32'h2222_2222, 1'b1, 32'h0000_0000};
        vecs[4] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[5] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[6] = '{1'b0, 32'h0000_0012, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[7] = '{1'b1, 32'h0000_00FC, 32'hA5A5_A5A5, 1'b0, 32'h0000_0000};
        vecs[8] = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 1'b0, 32'hA5A5_A5A5};
        vecs[9] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 1'b1, 32'h0000_0000};

        do_reset();
        @(negedge Clk);
        for (int g = 0; g < NL; g++) chk("ready_after_reset", g, 32'(ready[g]), 32'd1);
        tick();

        xact(1'b0, 32'h0, 32'h0);
        for (int g = 0; g < NL; g++) begin
            chk("load0_after_reset_rdata", g, got_rd[g], 32'h0);
            chk("load0_after_reset_err",   g, 32'(got_err[g]), 32'd0);
        end

        for (int i = 0; i < 10; i++) begin
            xact(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            for (int g = 0; g < NL; g++) begin
                chk($sformatf("vec%0d_rdata", i), g, got_rd[g], vecs[i].exp_rd);
                chk($sformatf("vec%0d_err", i),   g, 32'(got_err[g]), 32'(vecs[i].exp_err));
            end
        end

        // req_valid held high for 9 cycles: each lane re-accepts right after its RESP.
        for (int g = 0; g < NL; g++) cnt[g] = 0;
        drive(1'b1, 1'b0, 32'h10, '0);
        for (int k = 0; k < 18; k++) begin
            @(negedge Clk);
            for (int g = 0; g < NL; g++) if (rv[g]) cnt[g]++;
            if (rv[2]) pc.push_back(k);
            tick();
            if (k == 8) drive(1'b0, 1'b0, '0, '0);
        end
        for (int g = 0; g < NL; g++) chk("b2b_pulses", g, cnt[g], (g + 10) / (g + 2));
        chk("b2b_count", 2, pc.size(), 3);
        if (pc.size() == 3) begin
            chk("b2b_first_resp", 2, pc[0], 3);
            chk("b2b_spacing_1",  2, pc[1] - pc[0], 4);
            chk("b2b_spacing_2",  2, pc[2] - pc[1], 4);
        end

        // Reset lands while the multi-cycle lanes sit in WAIT of a store.
        for (int g = 0; g < NL; g++) cnt[g] = 0;
        drive(1'b1, 1'b1, 32'h20, 32'h1234_5678);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        Reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            for (int g = 0; g < NL; g++) if (rv[g]) cnt[g]++;
            tick();
            if (k == 1) Reset = 1'b1;
        end
        for (int g = 0; g < NL; g++) chk("abort_no_resp", g, cnt[g], 0);
        xact(1'b0, 32'h20, '0);
        for (int g = 0; g < NL; g++) chk("abort_readback", g, got_rd[g], 32'h0);

        // Random traffic, with occasional asynchronous reset pulses.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                drive(1'b0, 1'b0, '0, '0);
                Reset = 1'b0;
                tick();
                Reset = 1'b1;
            end else begin
                case ($urandom_range(0, 9))
                    7:       a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
                    8:       a = 32'h100 + (32'($urandom_range(0, 15)) << 2);
                    9:       a = $urandom;
                    default: a = 32'($urandom_range(0, 15)) << 2;
                endcase
                drive(r < 62, 1'($urandom_range(0, 1)), a, $urandom);
                tick();
            end
        end
        drive(1'b0, 1'b0, '0, '0);
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
